// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: MIPS load/store opcodes,
// error-cause encoding and opcode classification helpers.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_ADEL = 2'd1,
        ERR_ADES = 2'd2,
        ERR_BUS  = 2'd3
    } err_kind_e;

    function automatic logic is_load(input logic [5:0] op);
        logic r;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        logic r;
        case (op)
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load(op) | is_store(op);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_ctrl.sv
// Combinational byte-lane logic: byte enables, store-data replication,
// load-data extension and alignment check for one load/store opcode.
module lane_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Lane selection, replication and extension per access size
    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
        misaligned = 1'b0;
        half_s     = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_s     = mem_rdata[{addr_lo, 3'b000} +: 8];
        case (opcode)
            OP_LW, OP_SW: begin
                be         = 4'b1111;
                wdata      = wdata_in;
                rdata_ext  = mem_rdata;
                misaligned = (addr_lo != 2'b00);
            end
            OP_LH, OP_LHU, OP_SH: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{wdata_in[15:0]}};
                misaligned = addr_lo[0];
                if (opcode == OP_LH) begin
                    rdata_ext = {{16{half_s[15]}}, half_s};
                end else begin
                    rdata_ext = {16'h0000, half_s};
                end
            end
            OP_LB, OP_LBU, OP_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{wdata_in[7:0]}};
                if (opcode == OP_LB) begin
                    rdata_ext = {{24{byte_s[7]}}, byte_s};
                end else begin
                    rdata_ext = {24'h00_0000, byte_s};
                end
            end
            default: begin
                be         = 4'b0000;
                wdata      = 32'h0000_0000;
                rdata_ext  = 32'h0000_0000;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the CPU control FSM and a ready-handshake
// memory: request sequencing, timeout, exceptions and registered results.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    err_kind_e   err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        adel_q, adel_d;
    logic        ades_q, ades_d;
    logic        bus_err_q, bus_err_d;

    logic        idle_s;
    logic [5:0]  lc_op_s;
    logic [1:0]  lc_addr_s;
    logic [3:0]  lc_be_s;
    logic [31:0] lc_wdata_s;
    logic [31:0] lc_rdata_s;
    logic        lc_misaligned_s;
    logic [7:0]  cnt_inc_s;

    // In IDLE the lane logic looks at the live request; afterwards at the latched one
    assign idle_s    = (state_q == S_IDLE);
    assign lc_op_s   = idle_s ? opcode : op_q;
    assign lc_addr_s = idle_s ? addr[1:0] : addr_lo_q;
    assign cnt_inc_s = cnt_q + 8'd1;

    lane_ctrl u_lane_ctrl (
        .opcode     (lc_op_s),
        .addr_lo    (lc_addr_s),
        .wdata_in   (wdata_in),
        .mem_rdata  (mem_rdata),
        .be         (lc_be_s),
        .wdata      (lc_wdata_s),
        .rdata_ext  (lc_rdata_s),
        .misaligned (lc_misaligned_s)
    );

    // Next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        adel_d      = 1'b0;
        ades_d      = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && is_mem_op(opcode)) begin
                    op_d      = opcode;
                    addr_lo_d = addr[1:0];
                    if (lc_misaligned_s) begin
                        state_d = S_ERR;
                        err_d   = is_store(opcode) ? ERR_ADES : ERR_ADEL;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(opcode);
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = lc_be_s;
                        mem_wdata_d = lc_wdata_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // Completion wins over a simultaneous timeout
                if (mem_ready) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    if (is_load(op_q)) begin
                        rdata_d = lc_rdata_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_inc_s == TIMEOUT) begin
                    state_d   = S_ERR;
                    err_d     = ERR_BUS;
                    cnt_d     = cnt_inc_s;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
                err_d   = ERR_NONE;
                case (err_q)
                    ERR_ADEL: adel_d    = 1'b1;
                    ERR_ADES: ades_d    = 1'b1;
                    ERR_BUS:  bus_err_d = 1'b1;
                    default:  adel_d    = 1'b0;
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            err_q       <= ERR_NONE;
            cnt_q       <= 8'd0;
            op_q        <= 6'd0;
            addr_lo_q   <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            done_q      <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            adel_q      <= adel_d;
            ades_q      <= ades_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign adel      = adel_q;
    assign ades      = ades_q;
    assign bus_err   = bus_err_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 8'd255, maximum mem_ready wait cycles before bus error.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request from the CPU control FSM, sampled only in IDLE.
REQ-005 opcode  input  6  MIPS opcode [31:26]: lw, lh, lhu, lb, lbu, sw, sh, sb.
REQ-006 addr  input  32  effective byte address.
REQ-007 wdata_in  input  32  store data from register file (rt).
REQ-008 mem_req  output  1  memory request, held until accepted.
REQ-009 mem_we  output  1  write strobe, valid with mem_req.
REQ-010 mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-011 mem_be  output  4  byte enables.
REQ-012 mem_wdata  output  32  store data replicated into the selected lanes.
REQ-013 mem_rdata  input  32  read word, valid in the cycle mem_ready=1.
REQ-014 mem_ready  input  1  memory completion.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 rdata  output  32  extended load result, registered, held until next load completes.
REQ-017 adel / ades  output  1 each  misaligned load / store exception, one-cycle pulse.
REQ-018 bus_err  output  1  timeout pulse, one cycle.

Function
REQ-019 States: IDLE, REQ, DONE, ERR; encoding local to the module.
REQ-020 IDLE + start: operands latched; misaligned -> ERR, else -> REQ; start in any other state is ignored.
REQ-021 Misaligned: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]=1; byte ops are never misaligned.
REQ-022 Unrecognised opcode at start: no state change, no outputs.
REQ-023 be: word 4'b1111; half 4'b0011 (addr[1]=0) / 4'b1100 (addr[1]=1); byte 4'b0001<<addr[1:0].
REQ-024 Store data: sw passes through; sh replicates wdata_in[15:0] to both halves; sb replicates [7:0] to all four lanes.
REQ-025 REQ: mem_req=1 with mem_we/mem_addr/mem_be/mem_wdata stable every cycle until mem_ready is sampled high.
REQ-026 mem_ready in REQ: loads capture the extended mem_rdata into rdata that edge; -> DONE.
REQ-027 Extension: lh/lb sign-extend the lane selected by be; lhu/lbu zero-extend; lw unchanged.
REQ-028 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-029 Minimum latency: start at cycle N, mem_ready at N+1 -> done at N+2.
REQ-030 Wait counter: 8 bit, cleared on entry to REQ, incremented per REQ cycle without mem_ready; reaching TIMEOUT -> ERR with bus_err; rdata unchanged.
REQ-031 mem_ready in the same cycle the counter reaches TIMEOUT: the completion takes precedence, no bus_err.
REQ-032 ERR: exactly one of adel/ades/bus_err pulses for one cycle, then -> IDLE; done stays low.
REQ-033 mem_ready outside REQ is ignored.
REQ-034 Stores leave rdata unchanged.

Reset
REQ-035 rst: state IDLE; counter 0; mem_req, mem_we, done, adel, ades, bus_err 0; mem_be 4'b0000; rdata, mem_addr, mem_wdata 32'h0.
REQ-036 rst has priority over every other input, including mid-REQ; the pending transaction is dropped with no done and no exception.

Structure
REQ-037 Opcode constants (lw, lh, lhu, lb, lbu, sw, sh, sb) come from the shared head definitions file, not local literals.
REQ-038 Combinational be/extension logic lives in one sub-module, lane_ctrl (inputs: opcode, addr[1:0], wdata_in, mem_rdata; outputs: be, aligned wdata, extended load data, misaligned flag).
REQ-039 FSM, timeout counter and output registers live in mem_access_ctrl.

Verification
REQ-040 lb addr=0x1003, mem_rdata=0x80FF_FFFF, ready after 2 waits -> mem_be=4'b1000, rdata=0xFFFF_FF80, done 4 cycles after start.
REQ-041 lhu addr=0x2002, mem_rdata=0x8001_1234, immediate ready -> mem_be=4'b1100, rdata=0x0000_8001, done at start+2.
REQ-042 sb addr=0x0001, wdata_in=0x0000_00A5 -> mem_we=1, mem_be=4'b0010, mem_wdata=0xA5A5_A5A5; rdata unchanged.
REQ-043 lw addr=0x0006 -> adel pulse at start+2, no mem_req; sh addr=0x0003 -> ades likewise.
REQ-044 lw with mem_ready never asserted, TIMEOUT=4 -> bus_err once after 4 REQ cycles, then IDLE; second bench: mem_ready arrives in the cycle the counter reaches 4 -> done, no bus_err.
REQ-045 rst during REQ wait -> next cycle IDLE, mem_req=0, no done; a following start is accepted normally.
